// File: rtl/commit_stage_pkg.sv
// Shared types for the commit stage: decoded op enables, trap bundle,
// commit sequencing states and the mtvec mode-bit mask.
package commit_stage_pkg;

    // Write enables carried by the decoded op.
    typedef struct packed {
        logic intRegWriteEnable;
        logic fpRegWriteEnable;
        logic csrWriteEnable;
    } Op;

    // Trap report attached to an executed instruction.
    typedef struct packed {
        logic        valid;
        logic [3:0]  cause;
        logic [31:0] value;
    } TrapInfo;

    // Commit sequencing states.
    typedef enum logic [1:0] {
        RESET      = 2'd0,
        IDLE       = 2'd1,
        TRAP_WRITE = 2'd2,
        REDIRECT   = 2'd3
    } CommitState;

    // Low mtvec bits select the vectoring mode, not part of the handler address.
    localparam logic [31:0] MTVEC_MODE_MASK = 32'h0000_0003;

    // Trap handler base address taken from mtvec (direct mode only).
    function automatic logic [31:0] trap_vector(input logic [31:0] mtvec);
        return mtvec & ~MTVEC_MODE_MASK;
    endfunction

endpackage

// File: rtl/commit_redirect_fsm.sv
// Commit sequencing FSM: owns the state register and generates the
// reset/trap/mret/branch redirects, the flush pulse, the stall window and
// the trap CSR update pulse. All outputs except accept/retire are registered.
module commit_redirect_fsm
    import commit_stage_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  TrapInfo     ex_trap_info,
    input  logic        ex_trap_return,
    input  logic        ex_branch_taken,
    input  logic [31:0] ex_branch_target,
    input  logic [31:0] csr_mtvec,
    input  logic [31:0] csr_mepc,
    output logic        accept,
    output logic        retire,
    output logic        trap_we,
    output logic [31:0] trap_epc,
    output logic [3:0]  trap_cause,
    output logic [31:0] trap_value,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        stall,
    output CommitState  debug_state
);

    CommitState state;

    assign debug_state = state;

    // Handshake: a bundle is consumed when ex_valid is high at a clock edge
    // while the FSM is IDLE and the registered flush is low; a bundle present
    // during a flush cycle is a squashed younger instruction and is dropped.
    // Upstream must hold its bundle while stall is high (inputs are ignored).
    assign accept = (state == IDLE) && ex_valid && !flush;
    assign retire = accept && !ex_trap_info.valid;

    // Sequencing and registered redirect/flush/stall/trap-pulse generation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= RESET;
            trap_we        <= 1'b0;
            trap_epc       <= 32'h0;
            trap_cause     <= 4'h0;
            trap_value     <= 32'h0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'h0;
            flush          <= 1'b0;
            stall          <= 1'b0;
        end else begin
            trap_we        <= 1'b0;
            trap_epc       <= 32'h0;
            trap_cause     <= 4'h0;
            trap_value     <= 32'h0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'h0;
            flush          <= 1'b0;
            stall          <= 1'b0;
            case (state)
                RESET: begin
                    redirect_valid <= 1'b1;
                    redirect_pc    <= RESET_VECTOR;
                    flush          <= 1'b1;
                    state          <= IDLE;
                end
                IDLE: begin
                    if (accept) begin
                        if (ex_trap_info.valid) begin
                            trap_we    <= 1'b1;
                            trap_epc   <= ex_pc;
                            trap_cause <= ex_trap_info.cause;
                            trap_value <= ex_trap_info.value;
                            stall      <= 1'b1;
                            state      <= TRAP_WRITE;
                        end else if (ex_trap_return) begin
                            redirect_valid <= 1'b1;
                            redirect_pc    <= csr_mepc;
                            flush          <= 1'b1;
                        end else if (ex_branch_taken) begin
                            redirect_valid <= 1'b1;
                            redirect_pc    <= ex_branch_target;
                            flush          <= 1'b1;
                        end
                    end
                end
                TRAP_WRITE: begin
                    redirect_valid <= 1'b1;
                    redirect_pc    <= trap_vector(csr_mtvec);
                    flush          <= 1'b1;
                    stall          <= 1'b1;
                    state          <= REDIRECT;
                end
                REDIRECT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/commit_stage.sv
// Commit stage: retires one execute-stage bundle per cycle, performing the
// register-file and CSR writes, counting retired instructions and handing
// trap/mret/branch sequencing to commit_redirect_fsm.
// Optional build macro RAFI_COMMIT_TRACE_EN adds a registered retire trace port.
module commit_stage
    import commit_stage_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h8000_0000,
    parameter int          INSTRET_W    = 64
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 exValid,
    input  logic [31:0]          exPc,
    input  Op                    exOp,
    input  logic [11:0]          exCsrAddr,
    input  logic [4:0]           exDstRegAddr,
    input  logic [31:0]          exDstIntRegValue,
    input  logic [63:0]          exDstFpRegValue,
    input  logic                 exBranchTaken,
    input  logic [31:0]          exBranchTarget,
    input  TrapInfo              exTrapInfo,
    input  logic                 exTrapReturn,
    input  logic [31:0]          exDebugInsn,
    input  logic [31:0]          csrMtvec,
    input  logic [31:0]          csrMepc,
    output logic                 intRegWe,
    output logic [4:0]           intRegAddr,
    output logic [31:0]          intRegValue,
    output logic                 fpRegWe,
    output logic [4:0]           fpRegAddr,
    output logic [63:0]          fpRegValue,
    output logic                 csrWe,
    output logic [11:0]          csrAddr,
    output logic [31:0]          csrValue,
    output logic                 trapWe,
    output logic [31:0]          trapEpc,
    output logic [3:0]           trapCause,
    output logic [31:0]          trapValue,
    output logic                 redirectValid,
    output logic [31:0]          redirectPc,
    output logic                 flush,
    output logic                 stall,
    output logic [INSTRET_W-1:0] instret
`ifdef RAFI_COMMIT_TRACE_EN
    ,
    output logic                 traceValid,
    output logic [31:0]          tracePc,
    output logic [31:0]          traceInsn,
    output logic [63:0]          traceCycle
`endif
);

    logic       accept;
    logic       retire;
    CommitState commit_state;

    commit_redirect_fsm #(
        .RESET_VECTOR(RESET_VECTOR)
    ) u_redirect_fsm (
        .clk             (clk),
        .rst_n           (rstN),
        .ex_valid        (exValid),
        .ex_pc           (exPc),
        .ex_trap_info    (exTrapInfo),
        .ex_trap_return  (exTrapReturn),
        .ex_branch_taken (exBranchTaken),
        .ex_branch_target(exBranchTarget),
        .csr_mtvec       (csrMtvec),
        .csr_mepc        (csrMepc),
        .accept          (accept),
        .retire          (retire),
        .trap_we         (trapWe),
        .trap_epc        (trapEpc),
        .trap_cause      (trapCause),
        .trap_value      (trapValue),
        .redirect_valid  (redirectValid),
        .redirect_pc     (redirectPc),
        .flush           (flush),
        .stall           (stall),
        .debug_state     (commit_state)
    );

    // Writeback of retired bundles and the retired-instruction counter.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            intRegWe    <= 1'b0;
            intRegAddr  <= 5'h0;
            intRegValue <= 32'h0;
            fpRegWe     <= 1'b0;
            fpRegAddr   <= 5'h0;
            fpRegValue  <= 64'h0;
            csrWe       <= 1'b0;
            csrAddr     <= 12'h0;
            csrValue    <= 32'h0;
            instret     <= '0;
        end else begin
            // r0 is hardwired to zero, so its writes never reach the file.
            intRegWe <= retire && exOp.intRegWriteEnable && (exDstRegAddr != 5'd0);
            fpRegWe  <= retire && exOp.fpRegWriteEnable;
            csrWe    <= retire && exOp.csrWriteEnable;
            if (retire) begin
                intRegAddr  <= exDstRegAddr;
                intRegValue <= exDstIntRegValue;
                fpRegAddr   <= exDstRegAddr;
                fpRegValue  <= exDstFpRegValue;
                csrAddr     <= exCsrAddr;
                csrValue    <= exDstIntRegValue;
                instret     <= instret + INSTRET_W'(1);
            end
        end
    end

`ifdef RAFI_COMMIT_TRACE_EN
    // Trace of every retired or trapping instruction plus a free-running cycle count.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            traceValid <= 1'b0;
            tracePc    <= 32'h0;
            traceInsn  <= 32'h0;
            traceCycle <= 64'h0;
        end else begin
            traceValid <= accept;
            traceCycle <= traceCycle + 64'd1;
            if (accept) begin
                tracePc   <= exPc;
                traceInsn <= exDebugInsn;
            end
        end
    end
`else
    logic unused_debug_insn;
    assign unused_debug_insn = ^exDebugInsn;
`endif

endmodule

// File: tb/tb_commit_stage.sv
// Testbench for commit_stage: directed scenarios followed by randomized
// bundles checked against a cycle-level behavioural model.
module tb_commit_stage;
    import commit_stage_pkg::*;

    logic        clk;
    logic        rstN;
    logic        exValid;
    logic [31:0] exPc;
    Op           exOp;
    logic [11:0] exCsrAddr;
    logic [4:0]  exDstRegAddr;
    logic [31:0] exDstIntRegValue;
    logic [63:0] exDstFpRegValue;
    logic        exBranchTaken;
    logic [31:0] exBranchTarget;
    TrapInfo     exTrapInfo;
    logic        exTrapReturn;
    logic [31:0] exDebugInsn;
    logic [31:0] csrMtvec;
    logic [31:0] csrMepc;
    logic        intRegWe;
    logic [4:0]  intRegAddr;
    logic [31:0] intRegValue;
    logic        fpRegWe;
    logic [4:0]  fpRegAddr;
    logic [63:0] fpRegValue;
    logic        csrWe;
    logic [11:0] csrAddr;
    logic [31:0] csrValue;
    logic        trapWe;
    logic [31:0] trapEpc;
    logic [3:0]  trapCause;
    logic [31:0] trapValue;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic        flush;
    logic        stall;
    logic [63:0] instret;

    int checks = 0;
    int passed = 0;

    commit_stage dut (
        .clk(clk), .rstN(rstN), .exValid(exValid), .exPc(exPc), .exOp(exOp),
        .exCsrAddr(exCsrAddr), .exDstRegAddr(exDstRegAddr),
        .exDstIntRegValue(exDstIntRegValue), .exDstFpRegValue(exDstFpRegValue),
        .exBranchTaken(exBranchTaken), .exBranchTarget(exBranchTarget),
        .exTrapInfo(exTrapInfo), .exTrapReturn(exTrapReturn), .exDebugInsn(exDebugInsn),
        .csrMtvec(csrMtvec), .csrMepc(csrMepc),
        .intRegWe(intRegWe), .intRegAddr(intRegAddr), .intRegValue(intRegValue),
        .fpRegWe(fpRegWe), .fpRegAddr(fpRegAddr), .fpRegValue(fpRegValue),
        .csrWe(csrWe), .csrAddr(csrAddr), .csrValue(csrValue),
        .trapWe(trapWe), .trapEpc(trapEpc), .trapCause(trapCause), .trapValue(trapValue),
        .redirectValid(redirectValid), .redirectPc(redirectPc),
        .flush(flush), .stall(stall), .instret(instret)
    );

    wire any_out = |{intRegWe, intRegAddr, intRegValue, fpRegWe, fpRegAddr, fpRegValue,
                     csrWe, csrAddr, csrValue, trapWe, trapEpc, trapCause, trapValue,
                     redirectValid, redirectPc, flush, stall, instret};

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic clear_bundle();
        exValid = 1'b0; exPc = 32'h0; exOp = '0; exCsrAddr = 12'h0;
        exDstRegAddr = 5'h0; exDstIntRegValue = 32'h0; exDstFpRegValue = 64'h0;
        exBranchTaken = 1'b0; exBranchTarget = 32'h0; exTrapInfo = '0;
        exTrapReturn = 1'b0; exDebugInsn = 32'h0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        clear_bundle();
        csrMtvec = 32'h0; csrMepc = 32'h0;
        repeat (3) step();
        checks++;
        if (any_out !== 1'b0) $display("FAIL reset_outputs: some output nonzero during reset, instret=%h", instret);
        else passed++;
        rstN = 1'b1;
        step();
        checks++;
        if ({redirectValid, redirectPc, flush, instret} !== {1'b1, 32'h8000_0000, 1'b1, 64'd0})
            $display("FAIL reset_redirect: got v=%0b pc=%h flush=%0b instret=%0d, expected 1 80000000 1 0",
                     redirectValid, redirectPc, flush, instret);
        else passed++;
        step();
        checks++;
        if ({redirectValid, flush} !== 2'b00)
            $display("FAIL reset_pulse_len: got v=%0b flush=%0b, expected 0 0", redirectValid, flush);
        else passed++;
    endtask

    task automatic test_int_write();
        clear_bundle();
        exValid = 1'b1; exOp.intRegWriteEnable = 1'b1; exDstRegAddr = 5'd5; exDstIntRegValue = 32'h1234;
        step();
        checks++;
        if ({intRegWe, intRegAddr, intRegValue, instret} !== {1'b1, 5'd5, 32'h1234, 64'd1})
            $display("FAIL int_write: got we=%0b addr=%0d val=%h instret=%0d, expected 1 5 1234 1",
                     intRegWe, intRegAddr, intRegValue, instret);
        else passed++;
        exDstRegAddr = 5'd0; exDstIntRegValue = 32'h5555;
        step();
        checks++;
        if ({intRegWe, instret} !== {1'b0, 64'd2})
            $display("FAIL r0_write: got we=%0b instret=%0d, expected 0 2", intRegWe, instret);
        else passed++;
        clear_bundle();
        exValid = 1'b1; exOp.fpRegWriteEnable = 1'b1; exDstRegAddr = 5'd7; exDstFpRegValue = 64'hDEAD_BEEF_0BAD_F00D;
        step();
        checks++;
        if ({fpRegWe, fpRegAddr, fpRegValue, intRegWe, instret} !== {1'b1, 5'd7, 64'hDEAD_BEEF_0BAD_F00D, 1'b0, 64'd3})
            $display("FAIL fp_write: got we=%0b addr=%0d val=%h instret=%0d, expected 1 7 deadbeef0badf00d 3",
                     fpRegWe, fpRegAddr, fpRegValue, instret);
        else passed++;
        clear_bundle();
        step();
        checks++;
        if ({fpRegWe, intRegWe, csrWe, instret} !== {3'b000, 64'd3})
            $display("FAIL invalid_bundle: got we=%0b%0b%0b instret=%0d, expected 000 3", fpRegWe, intRegWe, csrWe, instret);
        else passed++;
    endtask

    task automatic test_trap();
        clear_bundle();
        exValid = 1'b1; exPc = 32'h100; exTrapInfo = '{valid: 1'b1, cause: 4'd2, value: 32'hDEAD};
        exOp.intRegWriteEnable = 1'b1; exDstRegAddr = 5'd3;
        csrMtvec = 32'h201;
        step();
        checks++;
        if ({trapWe, trapEpc, trapCause, trapValue, stall, redirectValid, intRegWe, instret} !==
            {1'b1, 32'h100, 4'd2, 32'hDEAD, 1'b1, 1'b0, 1'b0, 64'd3})
            $display("FAIL trap_write: got we=%0b epc=%h cause=%0d val=%h stall=%0b rv=%0b iwe=%0b instret=%0d, expected 1 100 2 dead 1 0 0 3",
                     trapWe, trapEpc, trapCause, trapValue, stall, redirectValid, intRegWe, instret);
        else passed++;
        // A fresh bundle during the sequence must be ignored.
        clear_bundle();
        exValid = 1'b1; exOp.intRegWriteEnable = 1'b1; exDstRegAddr = 5'd9; exBranchTaken = 1'b1; exBranchTarget = 32'h7770;
        step();
        checks++;
        if ({redirectValid, redirectPc, flush, stall, trapWe, intRegWe, instret} !==
            {1'b1, 32'h200, 1'b1, 1'b1, 1'b0, 1'b0, 64'd3})
            $display("FAIL trap_redirect: got rv=%0b pc=%h flush=%0b stall=%0b twe=%0b iwe=%0b instret=%0d, expected 1 200 1 1 0 0 3",
                     redirectValid, redirectPc, flush, stall, trapWe, intRegWe, instret);
        else passed++;
        step();
        checks++;
        if ({redirectValid, flush, stall, intRegWe, instret} !== {4'b0000, 64'd3})
            $display("FAIL trap_done: got rv=%0b flush=%0b stall=%0b iwe=%0b instret=%0d, expected 0 0 0 0 3",
                     redirectValid, flush, stall, intRegWe, instret);
        else passed++;
    endtask

    task automatic test_trap_branch();
        clear_bundle();
        exValid = 1'b1; exPc = 32'h440; exTrapInfo = '{valid: 1'b1, cause: 4'd11, value: 32'h0};
        exBranchTaken = 1'b1; exBranchTarget = 32'h4444; exTrapReturn = 1'b1;
        csrMtvec = 32'h302; csrMepc = 32'h9990;
        step();
        checks++;
        if ({trapWe, trapCause, redirectValid, flush} !== {1'b1, 4'd11, 1'b0, 1'b0})
            $display("FAIL trap_prio_1: got twe=%0b cause=%0d rv=%0b flush=%0b, expected 1 11 0 0",
                     trapWe, trapCause, redirectValid, flush);
        else passed++;
        clear_bundle();
        step();
        checks++;
        if ({redirectValid, redirectPc} !== {1'b1, 32'h300})
            $display("FAIL trap_prio_2: got rv=%0b pc=%h, expected 1 300", redirectValid, redirectPc);
        else passed++;
        step();
    endtask

    task automatic test_mret();
        clear_bundle();
        exValid = 1'b1; exTrapReturn = 1'b1; exBranchTaken = 1'b1; exBranchTarget = 32'h1111;
        exOp.csrWriteEnable = 1'b1; exCsrAddr = 12'h300; exDstIntRegValue = 32'h88;
        csrMepc = 32'h3000;
        step();
        checks++;
        if ({redirectValid, redirectPc, flush, csrWe, csrAddr, csrValue, instret} !==
            {1'b1, 32'h3000, 1'b1, 1'b1, 12'h300, 32'h88, 64'd4})
            $display("FAIL mret: got rv=%0b pc=%h flush=%0b cwe=%0b caddr=%h cval=%h instret=%0d, expected 1 3000 1 1 300 88 4",
                     redirectValid, redirectPc, flush, csrWe, csrAddr, csrValue, instret);
        else passed++;
        // The bundle seen during the flush cycle is squashed.
        clear_bundle();
        exValid = 1'b1; exOp.intRegWriteEnable = 1'b1; exDstRegAddr = 5'd4;
        step();
        checks++;
        if ({intRegWe, flush, instret} !== {1'b0, 1'b0, 64'd4})
            $display("FAIL mret_squash: got iwe=%0b flush=%0b instret=%0d, expected 0 0 4", intRegWe, flush, instret);
        else passed++;
    endtask

    task automatic test_back_to_back();
        clear_bundle();
        exValid = 1'b1; exBranchTaken = 1'b1; exBranchTarget = 32'hA000;
        exOp.intRegWriteEnable = 1'b1; exDstRegAddr = 5'd1; exDstIntRegValue = 32'h204;
        step();
        checks++;
        if ({redirectValid, redirectPc, flush, intRegWe, intRegAddr, intRegValue, instret} !==
            {1'b1, 32'hA000, 1'b1, 1'b1, 5'd1, 32'h204, 64'd5})
            $display("FAIL branch: got rv=%0b pc=%h flush=%0b iwe=%0b addr=%0d val=%h instret=%0d, expected 1 a000 1 1 1 204 5",
                     redirectValid, redirectPc, flush, intRegWe, intRegAddr, intRegValue, instret);
        else passed++;
        exBranchTarget = 32'hB000;
        step();
        checks++;
        if ({redirectValid, flush, intRegWe, instret} !== {3'b000, 64'd5})
            $display("FAIL branch_squash: got rv=%0b flush=%0b iwe=%0b instret=%0d, expected 0 0 0 5",
                     redirectValid, flush, intRegWe, instret);
        else passed++;
        clear_bundle();
    endtask

    task automatic test_reset_mid_trap();
        clear_bundle();
        exValid = 1'b1; exPc = 32'h500; exTrapInfo = '{valid: 1'b1, cause: 4'd5, value: 32'h1};
        step();
        clear_bundle();
        checks++;
        if (trapWe !== 1'b1) $display("FAIL midtrap_enter: got twe=%0b, expected 1", trapWe);
        else passed++;
        rstN = 1'b0;
        #1;
        checks++;
        if (any_out !== 1'b0) $display("FAIL midtrap_async_reset: outputs nonzero after reset assert, twe=%0b stall=%0b", trapWe, stall);
        else passed++;
        step();
        step();
        rstN = 1'b1;
        step();
        checks++;
        if ({redirectValid, redirectPc, flush, trapWe, stall} !== {1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b0})
            $display("FAIL midtrap_rearm: got rv=%0b pc=%h flush=%0b twe=%0b stall=%0b, expected 1 80000000 1 0 0",
                     redirectValid, redirectPc, flush, trapWe, stall);
        else passed++;
        step();
        checks++;
        if ({trapWe, redirectValid, stall, instret} !== {3'b000, 64'd0})
            $display("FAIL midtrap_after: got twe=%0b rv=%0b stall=%0b instret=%0d, expected 0 0 0 0",
                     trapWe, redirectValid, stall, instret);
        else passed++;
    endtask

    // Randomized bundles against a model: a bundle is consumed unless it falls
    // in the shadow of an earlier redirect (1 cycle) or trap (2 cycles).
    task automatic test_random();
        int          shadow = 0;
        bit          trap_pending = 0;
        logic [63:0] exp_instret = 64'd0;
        logic [2:0]  op_bits;
        for (int i = 0; i < 600; i++) begin
            bit          e_int, e_fp, e_csr, e_trap, e_rv, e_fl, e_st, take;
            logic [31:0] e_pc;
            logic [31:0] e_epc, e_tval, e_ival;
            logic [3:0]  e_cause;
            logic [4:0]  e_addr;
            logic [63:0] e_fval;
            logic [11:0] e_caddr;
            exValid = ($urandom_range(0, 3) != 0);
            exPc = $urandom;
            op_bits = 3'($urandom_range(0, 7));
            exOp = op_bits;
            exCsrAddr = 12'($urandom_range(0, 4095));
            exDstRegAddr = 5'($urandom_range(0, 31));
            exDstIntRegValue = $urandom;
            exDstFpRegValue = {$urandom, $urandom};
            exTrapInfo.valid = ($urandom_range(0, 9) == 0);
            exTrapInfo.cause = 4'($urandom_range(0, 15));
            exTrapInfo.value = $urandom;
            exTrapReturn = ($urandom_range(0, 9) == 0);
            exBranchTaken = ($urandom_range(0, 5) == 0);
            exBranchTarget = $urandom;
            exDebugInsn = $urandom;
            csrMtvec = $urandom;
            csrMepc = $urandom;
            e_int = 0; e_fp = 0; e_csr = 0; e_trap = 0; e_rv = 0; e_fl = 0; e_st = 0;
            e_pc = 0; e_epc = 0; e_tval = 0; e_cause = 0; e_addr = 0; e_ival = 0; e_fval = 0; e_caddr = 0;
            if (trap_pending) begin
                e_rv = 1; e_fl = 1; e_st = 1; trap_pending = 0;
                e_pc = csrMtvec - (csrMtvec % 4);
            end
            take = exValid && (shadow == 0);
            if (shadow > 0) shadow--;
            if (take) begin
                if (exTrapInfo.valid) begin
                    e_trap = 1; e_st = 1; trap_pending = 1; shadow = 2;
                    e_epc = exPc; e_cause = exTrapInfo.cause; e_tval = exTrapInfo.value;
                end else begin
                    exp_instret = exp_instret + 64'd1;
                    e_addr = exDstRegAddr; e_ival = exDstIntRegValue; e_fval = exDstFpRegValue; e_caddr = exCsrAddr;
                    e_int = exOp.intRegWriteEnable && (exDstRegAddr != 0);
                    e_fp = exOp.fpRegWriteEnable;
                    e_csr = exOp.csrWriteEnable;
                    if (exTrapReturn) begin
                        e_rv = 1; e_fl = 1; e_pc = csrMepc; shadow = 1;
                    end else if (exBranchTaken) begin
                        e_rv = 1; e_fl = 1; e_pc = exBranchTarget; shadow = 1;
                    end
                end
            end
            step();
            checks++;
            if ({intRegWe, fpRegWe, csrWe, trapWe, redirectValid, flush, stall} !== {e_int, e_fp, e_csr, e_trap, e_rv, e_fl, e_st})
                $display("FAIL rand_ctrl[%0d]: got iwe/fwe/cwe/twe/rv/fl/st=%b, expected %b", i,
                         {intRegWe, fpRegWe, csrWe, trapWe, redirectValid, flush, stall},
                         {e_int, e_fp, e_csr, e_trap, e_rv, e_fl, e_st});
            else passed++;
            checks++;
            if (instret !== exp_instret) $display("FAIL rand_instret[%0d]: got %0d, expected %0d", i, instret, exp_instret);
            else passed++;
            if (e_rv) begin
                checks++;
                if (redirectPc !== e_pc) $display("FAIL rand_redirect_pc[%0d]: got %h, expected %h", i, redirectPc, e_pc);
                else passed++;
            end
            if (e_trap) begin
                checks++;
                if ({trapEpc, trapCause, trapValue} !== {e_epc, e_cause, e_tval})
                    $display("FAIL rand_trap[%0d]: got %h/%0d/%h, expected %h/%0d/%h", i,
                             trapEpc, trapCause, trapValue, e_epc, e_cause, e_tval);
                else passed++;
            end
            if (e_int) begin
                checks++;
                if ({intRegAddr, intRegValue} !== {e_addr, e_ival})
                    $display("FAIL rand_int[%0d]: got %0d/%h, expected %0d/%h", i, intRegAddr, intRegValue, e_addr, e_ival);
                else passed++;
            end
            if (e_fp) begin
                checks++;
                if ({fpRegAddr, fpRegValue} !== {e_addr, e_fval})
                    $display("FAIL rand_fp[%0d]: got %0d/%h, expected %0d/%h", i, fpRegAddr, fpRegValue, e_addr, e_fval);
                else passed++;
            end
            if (e_csr) begin
                checks++;
                if ({csrAddr, csrValue} !== {e_caddr, e_ival})
                    $display("FAIL rand_csr[%0d]: got %h/%h, expected %h/%h", i, csrAddr, csrValue, e_caddr, e_ival);
                else passed++;
            end
        end
        clear_bundle();
    endtask

    initial begin
        test_reset();
        test_int_write();
        test_trap();
        test_trap_branch();
        test_mret();
        test_back_to_back();
        test_reset_mid_trap();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/commit_stage.md
Name: commit_stage

Overview:
- Consumer end of the execute-stage result bundle; connects to ExecuteStageIF through its NextStage modport, flattened here as ex* ports.
- Retires one instruction per cycle:
  - writes the int/fp register files and the CSR write port;
  - counts retired instructions;
  - sequences traps, trap returns and taken branches into a fetch redirect plus a pipeline flush.

Parameters:
- RESET_VECTOR, 32'h8000_0000, PC redirected to on the first cycle after reset release.
- INSTRET_W, 64, width of the retired-instruction counter.

Ports:
- clk  in  1  clock
- rstN  in  1  asynchronous active-low reset
- exValid  in  1  bundle valid
- exPc  in  32  instruction PC
- exOp  in  $bits(Op)  decoded op; uses intRegWriteEnable, fpRegWriteEnable, csrWriteEnable
- exCsrAddr  in  12  CSR address
- exDstRegAddr  in  5  destination register
- exDstIntRegValue  in  32  int result / CSR write value
- exDstFpRegValue  in  64  fp result
- exBranchTaken  in  1  branch/jump taken
- exBranchTarget  in  32  branch target
- exTrapInfo  in  $bits(TrapInfo)  {valid, cause[3:0], value[31:0]}
- exTrapReturn  in  1  mret
- exDebugInsn  in  32  raw instruction
- csrMtvec  in  32  current mtvec
- csrMepc  in  32  current mepc
- intRegWe/intRegAddr/intRegValue  out  1/5/32  int register write
- fpRegWe/fpRegAddr/fpRegValue  out  1/5/64  fp register write
- csrWe/csrAddr/csrValue  out  1/12/32  CSR write
- trapWe/trapEpc/trapCause/trapValue  out  1/32/4/32  trap CSR update pulse
- redirectValid/redirectPc  out  1/32  fetch redirect
- flush  out  1  kill all younger in-flight instructions
- stall  out  1  hold upstream stages
- instret  out  INSTRET_W  retired count

Behaviour:
- Reset (async, rstN=0):
  - all outputs 0; state RESET.
  - On the first clk after release: redirectValid=1, redirectPc=RESET_VECTOR, flush=1 for one cycle; then IDLE.
  - rstN asserted mid-trap sequence aborts the sequence; no trapWe is issued.
- Timing: all outputs registered; 1-cycle latency from the ex* sample edge.
- IDLE, exValid=1, no trap:
  - register writes gated by their exOp enables; r0 int writes are suppressed (intRegWe=0 when addr=0).
  - instret increments by 1 and wraps at 2^INSTRET_W.
- Priority when several events are set in the same bundle: trapInfo.valid > exTrapReturn > exBranchTaken.
- Trap (IDLE, exValid=1, trapInfo.valid):
  - no reg/CSR writes and no instret increment that cycle.
  - next cycle: trapWe=1 (epc=exPc, cause, value) and stall=1; state TRAP_WRITE.
  - TRAP_WRITE -> REDIRECT: redirectValid=1, redirectPc=csrMtvec & ~32'h3, flush=1.
  - REDIRECT -> IDLE. stall stays high from TRAP_WRITE through REDIRECT.
  - ex* inputs are ignored in TRAP_WRITE and REDIRECT.
- Trap return (exTrapReturn):
  - single cycle: redirectValid=1, redirectPc=csrMepc, flush=1.
  - instret increments; the CSR write of the same bundle is still performed.
- Taken branch (exBranchTaken):
  - single cycle: redirect to exBranchTarget, flush=1.
  - writeback (link register) performed; instret increments.
- exValid=0: write enables 0, no counting.
- On a flush cycle the bundle sampled in the same cycle is discarded as squashed.
- Back-to-back branches: each is handled independently; the younger one is normally squashed by the flush.

Optional Feature:
- RAFI_COMMIT_TRACE_EN defined:
  - adds registered traceValid(1), tracePc(32), traceInsn(32), traceCycle(64).
  - traceValid pulses for every retired instruction and every trapping instruction; traceCycle is a free-running cycle counter.
- Undefined: the trace ports are absent and no trace logic is generated.

Decomposition:
- CommitState enum {RESET, IDLE, TRAP_WRITE, REDIRECT} and the constant MTVEC_MODE_MASK go in ProcessorTypes.
- Op and TrapInfo are reused from OpTypes / ProcessorTypes.
- One sub-module: commit_redirect_fsm (state register, stall/flush/redirect generation). The writeback datapath and counter stay in commit_stage.

Test Plan:
- Reset release -> one cycle redirectValid=1, redirectPc=32'h8000_0000, flush=1; instret=0.
- Valid int write r5=32'h1234 -> next cycle intRegWe=1, intRegAddr=5, intRegValue=32'h1234, instret=1. A write to r0 -> intRegWe=0 and instret still increments.
- Trap, cause=2, pc=32'h100, value=32'hDEAD, csrMtvec=32'h201 ->
  - cycle1: trapWe=1, trapEpc=32'h100, trapCause=2, trapValue=32'hDEAD, stall=1;
  - cycle2: redirectPc=32'h200, flush=1, stall=1;
  - instret unchanged.
- Trap and branchTaken set together -> trap sequence only; no redirect to exBranchTarget.
- mret with csrMepc=32'h3000 -> redirectPc=32'h3000, flush=1, instret+1.
- rstN pulled low in TRAP_WRITE -> all outputs 0 immediately; after release the RESET_VECTOR redirect occurs and no trapWe is issued.
